// File: rtl/r2r_dac_pkg.sv
// Shared types and default widths for the R2R ladder waveform generator.
package r2r_dac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV_W  = 16;

    typedef enum logic [1:0] {
        MODE_EXT = 2'd0,
        MODE_SAW = 2'd1,
        MODE_TRI = 2'd2,
        MODE_SQR = 2'd3
    } mode_e;

endpackage

// File: rtl/r2r_clk_div.sv
// Loadable down-counting divider producing a one-cycle tick on each expiry.
module r2r_clk_div #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              restart,
    output logic              tick
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            div_reload <= '0;
            tick       <= 1'b0;
        end else begin
            // A new reload value only lands in the counter at the next expiry.
            if (load)
                div_reload <= DIV_W'(data);
            if (restart) begin
                div_cnt <= div_reload;
                tick    <= 1'b0;
            end else if (div_cnt == '0) begin
                div_cnt <= div_reload;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/r2r_dac_wavegen.sv
// R2R DAC driver: external passthrough or saw/triangle/square phase engine.
module r2r_dac_wavegen
    import r2r_dac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    input  logic              load_divider,
    input  logic              load_step,
    input  logic              hold,
    output logic [DATA_W-1:0] dac_out,
    output logic              tick,
    output logic              wrap
);

    localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};
    localparam logic [DATA_W:0]   TOP_EXT = {1'b0, {DATA_W{1'b1}}};

    mode_e             mode_q;
    logic              mode_chg;
    logic [DATA_W-1:0] phase, phase_nx;
    logic [DATA_W-1:0] step;
    logic              tri_down, down_nx;
    logic              wrap_nx;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] dac_nx;

    assign mode_chg = (mode_e'(mode) != mode_q);

    r2r_clk_div #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_divider),
        .data    (data),
        .restart (mode_chg),
        .tick    (tick)
    );

    always_comb begin
        phase_nx = phase;
        down_nx  = tri_down;
        wrap_nx  = 1'b0;
        sum      = {1'b0, phase} + {1'b0, step};
        if (tick && !hold) begin
            unique case (mode_q)
                MODE_SAW, MODE_SQR: begin
                    phase_nx = sum[DATA_W-1:0];
                    wrap_nx  = sum[DATA_W];
                end
                MODE_TRI: begin
                    // Both turnarounds clamp to the rail so the peaks are always hit.
                    if (!tri_down) begin
                        if (sum >= TOP_EXT) begin
                            phase_nx = ONES;
                            down_nx  = 1'b1;
                        end else begin
                            phase_nx = sum[DATA_W-1:0];
                        end
                    end else if (phase <= step) begin
                        phase_nx = '0;
                        down_nx  = 1'b0;
                        wrap_nx  = 1'b1;
                    end else begin
                        phase_nx = phase - step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (mode_q)
            MODE_EXT: dac_nx = data;
            MODE_SQR: dac_nx = {DATA_W{phase[DATA_W-1]}};
            default:  dac_nx = phase;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_EXT;
            phase    <= '0;
            tri_down <= 1'b0;
            step     <= DATA_W'(1);
            wrap     <= 1'b0;
            dac_out  <= '0;
        end else begin
            if (load_step)
                step <= data;
            dac_out <= dac_nx;
            if (mode_chg) begin
                mode_q   <= mode_e'(mode);
                phase    <= '0;
                tri_down <= 1'b0;
                wrap     <= 1'b0;
            end else begin
                phase    <= phase_nx;
                tri_down <= down_nx;
                wrap     <= wrap_nx;
            end
        end
    end

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Directed vector bench for r2r_dac_wavegen with hand-computed expectations.
module tb_r2r_dac_wavegen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] data;
    logic       load_divider, load_step, hold;
    logic [7:0] dac_out;
    logic       tick, wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic       ld_div;
        logic       ld_step;
        logic       hold;
        logic [7:0] dac;
        logic       tick;
        logic       wrap;
    } vec_t;

    vec_t tab[$];

    r2r_dac_wavegen #(.DATA_W(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .data         (data),
        .load_divider (load_divider),
        .load_step    (load_step),
        .hold         (hold),
        .dac_out      (dac_out),
        .tick         (tick),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] m, input logic [7:0] d,
                                input logic ld, input logic ls, input logic h,
                                input logic [7:0] e_dac, input logic e_tick,
                                input logic e_wrap);
        vec_t v;
        v.mode = m; v.data = d; v.ld_div = ld; v.ld_step = ls; v.hold = h;
        v.dac = e_dac; v.tick = e_tick; v.wrap = e_wrap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] d,
                         input logic ld, input logic ls, input logic h);
        mode = m; data = d; load_divider = ld; load_step = ls; hold = h;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_seg(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tab[i].mode, tab[i].data, tab[i].ld_div, tab[i].ld_step, tab[i].hold);
            cycle();
            chk($sformatf("vec%0d_dac", i), 32'(dac_out), 32'(tab[i].dac));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tab[i].tick));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tab[i].wrap));
        end
    endtask

    initial begin
        int a_end, b_end;

        // EXT passthrough, then switch to SAW (restart cycle + first tick)
        tab.push_back(mk(0, 8'hA5, 0, 0, 0, 8'hA5, 1, 0));
        tab.push_back(mk(0, 8'h3C, 0, 0, 0, 8'h3C, 1, 0));
        tab.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        a_end = tab.size();

        // SAW with divider reload 4 loaded mid-count
        tab.push_back(mk(1, 8'd4, 1, 0, 0, 8'd4, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd5, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd6, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd7, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd7, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd7, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd7, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd7, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd8, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd8, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd8, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd8, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd8, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd9, 0, 0));
        tab.push_back(mk(1, 8'd0, 1, 0, 0, 8'd9, 0, 0));
        // Switch to TRI with step 100: restart, no wrap
        tab.push_back(mk(2, 8'd100, 0, 1, 0, 8'd9, 0, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd100, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd200, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd255, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd155, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd55, 1, 1));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(2, 8'd0, 0, 0, 0, 8'd100, 1, 0));
        // SQR with step 64, hold for three cycles mid-run
        tab.push_back(mk(3, 8'd64, 0, 1, 0, 8'd200, 0, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'hFF, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'hFF, 1, 1));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 1, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 1, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 1, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'hFF, 1, 0));
        tab.push_back(mk(3, 8'd0, 0, 0, 0, 8'hFF, 1, 1));
        b_end = tab.size();

        // After reset: first tick on first edge, then SAW with default step 1
        tab.push_back(mk(0, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd0, 0, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd0, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd1, 1, 0));
        tab.push_back(mk(1, 8'd0, 0, 0, 0, 8'd2, 1, 0));

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        #2;
        chk("reset_dac", 32'(dac_out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_seg(0, a_end);

        // SAW step 1, divider 0: one count per cycle, single wrap on 255->0
        for (int k = 0; k < 260; k++) begin
            drive(1, 8'h00, 0, 0, 0);
            cycle();
            chk($sformatf("saw%0d_dac", k), 32'(dac_out), 32'(k % 256));
            chk($sformatf("saw%0d_wrap", k), 32'(wrap), (k == 255) ? 32'd1 : 32'd0);
        end

        run_seg(a_end, b_end);

        // Asynchronous reset mid-run while dac_out, tick and wrap are all high
        drive(0, 8'h00, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dac", 32'(dac_out), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_dac", 32'(dac_out), 32'd0);
        chk("held_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_seg(b_end, tab.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
